// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster
//   Transmitter end of the dual-lane common data bus. Completed results from
//   NUM_SRC functional units are queued in per-source FIFOs. A round-robin
//   arbiter then broadcasts up to two of them per slot. Each strobe is high
//   for exactly one cycle and is always followed by at least one low cycle,
//   because the listeners are edge-triggered.
//
// Ports
//   clock       system clock (rising edge)
//   reset       asynchronous, active-low reset
//   flush       synchronous squash; empties every FIFO and idles the bus
//   src_valid   per-source one-cycle push strobe
//   src_robNum  per-source ROB tag, source k at [6k+5:6k]
//   src_data    per-source result, source k at [32k+31:32k]
//   src_full    per-source FIFO full; the producer must not push
//   CDBiscast / CDBrobNum / CDBdata     lane 1 strobe, tag, value
//   CDBiscast2 / CDBrobNum2 / CDBdata2  lane 2 strobe, tag, value
//
// States
//   IDLE  | nothing buffered, bus quiet
//   BCAST | lane registers hold this slot's winners, strobes high
//   GAP   | mandatory low cycle after a broadcast
module cdb_broadcaster #(
    parameter int         NUM_SRC     = 4,
    parameter int         FIFO_DEPTH  = 2,
    parameter logic [5:0] INVALID_NUM = 6'b010000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [6*NUM_SRC-1:0]    src_robNum,
    input  logic [32*NUM_SRC-1:0]   src_data,
    output logic [NUM_SRC-1:0]      src_full,
    output logic                    CDBiscast,
    output logic [5:0]              CDBrobNum,
    output logic [31:0]             CDBdata,
    output logic                    CDBiscast2,
    output logic [5:0]              CDBrobNum2,
    output logic [31:0]             CDBdata2
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {IDLE, BCAST, GAP} state_t;

    state_t state_q, state_d;

    logic [5:0]    rob_mem_q [NUM_SRC][FIFO_DEPTH];
    logic [31:0]   dat_mem_q [NUM_SRC][FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q  [NUM_SRC];
    logic [PW-1:0] rd_ptr_q  [NUM_SRC];
    logic [CW-1:0] cnt_q     [NUM_SRC];

    logic [SW-1:0] rr_ptr_q, rr_ptr_d;

    logic          cast1_q, cast1_d, cast2_q, cast2_d;
    logic [5:0]    rob1_q, rob1_d, rob2_q, rob2_d;
    logic [31:0]   dat1_q, dat1_d, dat2_q, dat2_d;

    logic [NUM_SRC-1:0] nonempty, push_ok, pop;
    logic               any_ne, enter_bcast;
    logic               g1_vld, g2_vld;
    logic [SW-1:0]      g1_src, g2_src, idx, last_src;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            nonempty[k] = (cnt_q[k] != '0);
            src_full[k] = (cnt_q[k] == CW'(FIFO_DEPTH));
            // Fullness comes from registered state only, so a push into a
            // full FIFO is dropped even if that FIFO pops at the same edge.
            push_ok[k]  = src_valid[k] && !src_full[k] && !flush;
        end
        any_ne = |nonempty;
    end

    // One pass from rr_ptr: the first non-empty source takes lane 1, the next
    // one takes lane 2. Covering each index once keeps lane 2 off lane 1's FIFO.
    always_comb begin
        g1_vld = 1'b0;
        g1_src = '0;
        g2_vld = 1'b0;
        g2_src = '0;
        idx    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = SW'((int'(rr_ptr_q) + i) % NUM_SRC);
            if (nonempty[idx]) begin
                if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_src = idx;
                end else if (!g2_vld) begin
                    g2_vld = 1'b1;
                    g2_src = idx;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_ne) state_d = BCAST;
            BCAST:   state_d = GAP;
            GAP:     state_d = any_ne ? BCAST : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    assign enter_bcast = (state_d == BCAST);

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            pop[k] = enter_bcast &&
                     ((g1_vld && (g1_src == SW'(k))) || (g2_vld && (g2_src == SW'(k))));
        end
    end

    always_comb begin
        last_src = g2_vld ? g2_src : g1_src;
        rr_ptr_d = rr_ptr_q;
        if (enter_bcast) begin
            rr_ptr_d = (last_src == SW'(NUM_SRC - 1)) ? '0 : last_src + SW'(1);
        end
    end

    // Lanes fall back to the idle pattern on every edge that does not enter BCAST.
    always_comb begin
        cast1_d = 1'b0;
        rob1_d  = INVALID_NUM;
        dat1_d  = '0;
        cast2_d = 1'b0;
        rob2_d  = INVALID_NUM;
        dat2_d  = '0;
        if (enter_bcast && g1_vld) begin
            cast1_d = 1'b1;
            rob1_d  = rob_mem_q[g1_src][rd_ptr_q[g1_src]];
            dat1_d  = dat_mem_q[g1_src][rd_ptr_q[g1_src]];
            if (g2_vld) begin
                cast2_d = 1'b1;
                rob2_d  = rob_mem_q[g2_src][rd_ptr_q[g2_src]];
                dat2_d  = dat_mem_q[g2_src][rd_ptr_q[g2_src]];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            cast1_q  <= 1'b0;
            rob1_q   <= INVALID_NUM;
            dat1_q   <= '0;
            cast2_q  <= 1'b0;
            rob2_q   <= INVALID_NUM;
            dat2_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= flush ? '0 : rr_ptr_d;
            cast1_q  <= cast1_d;
            rob1_q   <= rob1_d;
            dat1_q   <= dat1_d;
            cast2_q  <= cast2_d;
            rob2_q   <= rob2_d;
            dat2_q   <= dat2_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                cnt_q[k]    <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (flush) begin
                    wr_ptr_q[k] <= '0;
                    rd_ptr_q[k] <= '0;
                    cnt_q[k]    <= '0;
                end else begin
                    if (push_ok[k]) wr_ptr_q[k] <= ptr_inc(wr_ptr_q[k]);
                    if (pop[k])     rd_ptr_q[k] <= ptr_inc(rd_ptr_q[k]);
                    cnt_q[k] <= cnt_q[k] + CW'(push_ok[k]) - CW'(pop[k]);
                end
            end
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the counters.
    always_ff @(posedge clock) begin
        for (int k = 0; k < NUM_SRC; k++) begin
            if (push_ok[k]) begin
                rob_mem_q[k][wr_ptr_q[k]] <= src_robNum[6*k +: 6];
                dat_mem_q[k][wr_ptr_q[k]] <= src_data[32*k +: 32];
            end
        end
    end

    assign CDBiscast  = cast1_q;
    assign CDBrobNum  = rob1_q;
    assign CDBdata    = dat1_q;
    assign CDBiscast2 = cast2_q;
    assign CDBrobNum2 = rob2_q;
    assign CDBdata2   = dat2_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Testbench for cdb_broadcaster: per-source scoreboard queues filled on push,
// drained and compared when the bus broadcasts.
module tb_cdb_broadcaster;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         flush = 1'b0;
    logic [3:0]   src_valid = '0;
    logic [23:0]  src_robNum = '0;
    logic [127:0] src_data = '0;
    logic [3:0]   src_full;
    logic         CDBiscast, CDBiscast2;
    logic [5:0]   CDBrobNum, CDBrobNum2;
    logic [31:0]  CDBdata, CDBdata2;

    cdb_broadcaster dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .src_valid  (src_valid),
        .src_robNum (src_robNum),
        .src_data   (src_data),
        .src_full   (src_full),
        .CDBiscast  (CDBiscast),
        .CDBrobNum  (CDBrobNum),
        .CDBdata    (CDBdata),
        .CDBiscast2 (CDBiscast2),
        .CDBrobNum2 (CDBrobNum2),
        .CDBdata2   (CDBdata2)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0]  rob;
        logic [31:0] dat;
    } ent_t;

    int n_chk  = 0;
    int n_pass = 0;

    ent_t sb_q [4][$];
    int   m_state = 0;     // 0 idle, 1 broadcast, 2 gap
    int   m_rr    = 0;
    int   n_acc   = 0;
    int   n_strobe = 0;
    int   n_src3  = 0;

    logic [5:0]  rob_a [4];
    logic [31:0] dat_a [4];
    logic [3:0]  seq = '0;
    bit          custom = 1'b0;

    logic        e_c1, e_c2;
    logic [5:0]  e_r1, e_r2;
    logic [31:0] e_d1, e_d2;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) sb_q[k].delete();
        m_state = 0;
        m_rr    = 0;
    endtask

    task automatic fill_def();
        for (int k = 0; k < 4; k++) begin
            logic [1:0] ks;
            ks = k[1:0];
            rob_a[k] = {ks, seq};
            dat_a[k] = $urandom;
            seq++;
        end
    endtask

    // Drives one cycle of stimulus, predicts the result of the next edge,
    // then compares the DUT just after that edge.
    task automatic step(input logic [3:0] v, input logic fl);
        bit ne [4];
        bit acc [4];
        bit any;
        int nxt, g1, g2, kk;
        ent_t e;
        if (!custom) fill_def();
        custom     = 1'b0;
        src_valid  = v;
        flush      = fl;
        src_robNum = {rob_a[3], rob_a[2], rob_a[1], rob_a[0]};
        src_data   = {dat_a[3], dat_a[2], dat_a[1], dat_a[0]};

        e_c1 = 1'b0; e_r1 = 6'd16; e_d1 = '0;
        e_c2 = 1'b0; e_r2 = 6'd16; e_d2 = '0;
        any = 1'b0;
        for (int k = 0; k < 4; k++) begin
            ne[k]  = (sb_q[k].size() != 0);
            acc[k] = v[k] && (sb_q[k].size() < 2);
            any    = any | ne[k];
        end
        if (fl) begin
            model_clear();
        end else begin
            nxt = (m_state == 1) ? 2 : (any ? 1 : 0);
            if (nxt == 1) begin
                g1 = -1;
                g2 = -1;
                for (int i = 0; i < 4; i++) begin
                    kk = (m_rr + i) % 4;
                    if (ne[kk]) begin
                        if (g1 < 0) g1 = kk;
                        else if (g2 < 0) g2 = kk;
                    end
                end
                e = sb_q[g1].pop_front();
                e_c1 = 1'b1; e_r1 = e.rob; e_d1 = e.dat;
                if (g2 >= 0) begin
                    e = sb_q[g2].pop_front();
                    e_c2 = 1'b1; e_r2 = e.rob; e_d2 = e.dat;
                end
                m_rr = (((g2 >= 0) ? g2 : g1) + 1) % 4;
            end
            for (int k = 0; k < 4; k++) begin
                if (acc[k]) begin
                    sb_q[k].push_back({rob_a[k], dat_a[k]});
                    n_acc++;
                end
            end
            m_state = nxt;
        end

        @(posedge clock);
        #1;
        chk("cast1", 64'(CDBiscast), 64'(e_c1));
        chk("rob1",  64'(CDBrobNum), 64'(e_r1));
        chk("dat1",  64'(CDBdata),   64'(e_d1));
        chk("cast2", 64'(CDBiscast2), 64'(e_c2));
        chk("rob2",  64'(CDBrobNum2), 64'(e_r2));
        chk("dat2",  64'(CDBdata2),   64'(e_d2));
        for (int k = 0; k < 4; k++) begin
            logic [3:0] fexp;
            fexp = '0;
            if (sb_q[k].size() == 2) fexp[k] = 1'b1;
            chk("src_full", 64'(src_full[k]), 64'(fexp[k]));
        end
        n_strobe += int'(CDBiscast) + int'(CDBiscast2);
        if (CDBiscast && CDBrobNum[5:4] == 2'd3)   n_src3++;
        if (CDBiscast2 && CDBrobNum2[5:4] == 2'd3) n_src3++;
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        src_valid = '0;
        flush     = 1'b0;
        model_clear();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        chk("rst_cast1", 64'(CDBiscast), 64'd0);
        chk("rst_cast2", 64'(CDBiscast2), 64'd0);
        chk("rst_rob1",  64'(CDBrobNum), 64'd16);
        chk("rst_rob2",  64'(CDBrobNum2), 64'd16);
        chk("rst_dat",   {CDBdata, CDBdata2}, 64'd0);
        chk("rst_full",  64'(src_full), 64'd0);
    endtask

    initial begin
        do_reset();

        // single result on source 1, then rotation continues from source 2
        fill_def();
        rob_a[1] = 6'd5;
        dat_a[1] = 32'hDEADBEEF;
        custom   = 1'b1;
        step(4'b0010, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0101, 1'b0);
        repeat (3) step(4'b0000, 1'b0);

        // dual broadcast from a fresh pointer
        do_reset();
        fill_def();
        rob_a[0] = 6'd3; dat_a[0] = 32'h11;
        rob_a[2] = 6'd7; dat_a[2] = 32'h22;
        custom   = 1'b1;
        step(4'b0101, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);

        // fairness under saturation, then drain and account for every entry
        do_reset();
        n_acc    = 0;
        n_strobe = 0;
        for (int c = 0; c < 40; c++) step(~src_full, 1'b0);
        repeat (8) step(4'b0000, 1'b0);
        chk("no_loss", 64'(n_strobe), 64'(n_acc));

        // full boundary on source 3
        do_reset();
        n_src3 = 0;
        step(4'b1011, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b1000, 1'b0);
        repeat (6) step(4'b0000, 1'b0);
        chk("src3_tags", 64'(n_src3), 64'd2);

        // flush during a gap with one entry still pending
        do_reset();
        step(4'b0111, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        repeat (3) step(4'b0000, 1'b0);
        step(4'b0100, 1'b0);
        repeat (2) step(4'b0000, 1'b0);

        // asynchronous reset in the middle of a broadcast
        do_reset();
        step(4'b0111, 1'b0);
        step(4'b0000, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        chk("async_cast1", 64'(CDBiscast), 64'd0);
        chk("async_cast2", 64'(CDBiscast2), 64'd0);
        chk("async_rob1",  64'(CDBrobNum), 64'd16);
        do_reset();
        repeat (3) step(4'b0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
